// File: rtl/uvmt_cv32e40x_sl_trigger_match_mem_seq_if.sv
// Instruction/trigger bundle presented to the sequential mload/mstore match checker.
interface uvmt_cv32e40x_sl_trigger_match_mem_seq_if #(
  parameter int unsigned NUM_TRIGGERS = 4,
  parameter int unsigned MAX_MEM_OPS  = 13,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BYTES_PER_OP = 4
);
  localparam int unsigned OPS_W = $clog2(MAX_MEM_OPS + 1);
  localparam int unsigned IDX_W = (MAX_MEM_OPS > 1) ? $clog2(MAX_MEM_OPS) : 1;

  logic                                 instr_valid_i;
  logic [MAX_MEM_OPS*XLEN-1:0]          mem_addr_i;
  logic [MAX_MEM_OPS*BYTES_PER_OP-1:0]  rmask_i;
  logic [MAX_MEM_OPS*BYTES_PER_OP-1:0]  wmask_i;
  logic [OPS_W-1:0]                     num_ops_i;
  logic                                 exception_i;
  logic [NUM_TRIGGERS-1:0]              match_execute_i;
  logic [NUM_TRIGGERS-1:0]              csr_conditions_i;
  logic [NUM_TRIGGERS*XLEN-1:0]         tdata1_i;
  logic [NUM_TRIGGERS*XLEN-1:0]         tdata2_i;

  logic                                 busy_o;
  logic                                 result_valid_o;
  logic [NUM_TRIGGERS-1:0]              trigger_match_mem_o;
  logic [IDX_W-1:0]                     match_op_idx_o;
  logic                                 match_found_o;
  logic                                 overrun_o;

  // Instruction source side
  modport master (
    output instr_valid_i, mem_addr_i, rmask_i, wmask_i, num_ops_i, exception_i,
           match_execute_i, csr_conditions_i, tdata1_i, tdata2_i,
    input  busy_o, result_valid_o, trigger_match_mem_o, match_op_idx_o,
           match_found_o, overrun_o
  );

  // Checker side
  modport slave (
    input  instr_valid_i, mem_addr_i, rmask_i, wmask_i, num_ops_i, exception_i,
           match_execute_i, csr_conditions_i, tdata1_i, tdata2_i,
    output busy_o, result_valid_o, trigger_match_mem_o, match_op_idx_o,
           match_found_o, overrun_o
  );
endinterface

// File: rtl/uvmt_cv32e40x_sl_trigger_match_mem_seq.sv
// Sequential expected-trigger-match checker for multi-access (push/pop, XIF)
// instructions: scans one memory op per clock and reports the first op whose
// word-grouped byte matches hit any enabled mload/mstore trigger.
module uvmt_cv32e40x_sl_trigger_match_mem_seq #(
  parameter int unsigned NUM_TRIGGERS = 4,
  parameter int unsigned MAX_MEM_OPS  = 13,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BYTES_PER_OP = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  uvmt_cv32e40x_sl_trigger_match_mem_seq_if.slave bus
);
  localparam int unsigned OPS_W = $clog2(MAX_MEM_OPS + 1);
  localparam int unsigned IDX_W = (MAX_MEM_OPS > 1) ? $clog2(MAX_MEM_OPS) : 1;
  localparam int unsigned KEY_W = XLEN - 2;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

  state_e                                     state_q, state_d;
  logic [IDX_W-1:0]                           cnt_q, cnt_d;
  logic [NUM_TRIGGERS-1:0]                    hit_vec_q, hit_vec_d;
  logic [IDX_W-1:0]                           hit_idx_q, hit_idx_d;
  logic                                       rv_q, rv_d;
  logic [NUM_TRIGGERS-1:0]                    vec_out_q, vec_out_d;
  logic [IDX_W-1:0]                           idx_out_q, idx_out_d;
  logic                                       found_out_q, found_out_d;
  logic                                       overrun_q, overrun_d;
  logic                                       capture_c;
  logic                                       short_c;
  logic [IDX_W-1:0]                           last_idx_c;

  // Shadow copy of the instruction; only the tdata1 fields the rule uses are kept
  logic [MAX_MEM_OPS-1:0][XLEN-1:0]           addr_q;
  logic [MAX_MEM_OPS-1:0][BYTES_PER_OP-1:0]   rmask_q;
  logic [MAX_MEM_OPS-1:0][BYTES_PER_OP-1:0]   wmask_q;
  logic [OPS_W-1:0]                           ops_q;
  logic [NUM_TRIGGERS-1:0]                    cond_q;
  logic [NUM_TRIGGERS-1:0]                    load_en_q;
  logic [NUM_TRIGGERS-1:0]                    store_en_q;
  logic [NUM_TRIGGERS-1:0][3:0]               kind_q;
  logic [NUM_TRIGGERS-1:0][XLEN-1:0]          tdata2_q;

  logic [XLEN-1:0]                            op_addr_c;
  logic [BYTES_PER_OP-1:0]                    op_rmask_c;
  logic [BYTES_PER_OP-1:0]                    op_wmask_c;
  logic [NUM_TRIGGERS-1:0][XLEN-1:0]          napot_care_c;
  logic [BYTES_PER_OP-1:0][XLEN-1:0]          byte_addr_c;
  logic [BYTES_PER_OP-1:0][KEY_W-1:0]         byte_key_c;
  logic [BYTES_PER_OP-1:0][NUM_TRIGGERS-1:0]  byte_cmp_c;
  logic [BYTES_PER_OP-1:0][NUM_TRIGGERS-1:0]  byte_hit_c;
  logic [NUM_TRIGGERS-1:0]                    op_vec_c;
  logic                                       op_hit_c;

  assign short_c    = (bus.num_ops_i == '0) || bus.exception_i || (|bus.match_execute_i);
  assign last_idx_c = IDX_W'(ops_q - OPS_W'(1));
  assign op_addr_c  = addr_q[cnt_q];
  assign op_rmask_c = rmask_q[cnt_q];
  assign op_wmask_c = wmask_q[cnt_q];

  // Capture the retiring instruction so later input changes cannot disturb the scan
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      ops_q      <= '0;
      cond_q     <= '0;
      load_en_q  <= '0;
      store_en_q <= '0;
      kind_q     <= '0;
      tdata2_q   <= '0;
    end else if (capture_c) begin
      addr_q   <= bus.mem_addr_i;
      rmask_q  <= bus.rmask_i;
      wmask_q  <= bus.wmask_i;
      ops_q    <= (bus.num_ops_i > OPS_W'(MAX_MEM_OPS)) ? OPS_W'(MAX_MEM_OPS) : bus.num_ops_i;
      cond_q   <= bus.csr_conditions_i;
      tdata2_q <= bus.tdata2_i;
      for (int t = 0; t < NUM_TRIGGERS; t++) begin
        load_en_q[t]  <= bus.tdata1_i[t*XLEN + 0];
        store_en_q[t] <= bus.tdata1_i[t*XLEN + 1];
        kind_q[t]     <= bus.tdata1_i[t*XLEN + 7 +: 4];
      end
    end
  end

  // NAPOT care mask: trailing ones of tdata2 plus the next bit are don't-care
  always_comb begin
    napot_care_c = '0;
    for (int t = 0; t < NUM_TRIGGERS; t++) begin
      napot_care_c[t] = ~(tdata2_q[t] ^ (tdata2_q[t] + XLEN'(1)));
    end
  end

  // Per-byte address compare and per-trigger byte match for the current op
  always_comb begin
    byte_addr_c = '0;
    byte_key_c  = '0;
    byte_cmp_c  = '0;
    byte_hit_c  = '0;
    for (int b = 0; b < BYTES_PER_OP; b++) begin
      byte_addr_c[b] = op_addr_c + XLEN'(b);
      byte_key_c[b]  = byte_addr_c[b][XLEN-1:2];
      for (int t = 0; t < NUM_TRIGGERS; t++) begin
        case (kind_q[t])
          4'd0:    byte_cmp_c[b][t] = (byte_addr_c[b] == tdata2_q[t]);
          4'd1:    byte_cmp_c[b][t] = (((byte_addr_c[b] ^ tdata2_q[t]) & napot_care_c[t]) == '0);
          4'd2:    byte_cmp_c[b][t] = (byte_addr_c[b] >= tdata2_q[t]);
          4'd3:    byte_cmp_c[b][t] = (byte_addr_c[b] <  tdata2_q[t]);
          default: byte_cmp_c[b][t] = 1'b0;
        endcase
        byte_hit_c[b][t] = cond_q[t]
                         & ((load_en_q[t] & op_rmask_c[b]) | (store_en_q[t] & op_wmask_c[b]))
                         & byte_cmp_c[b][t];
      end
    end
  end

  // Pick the first word group (by lowest byte index) that contains a matching byte
  always_comb begin : group_select
    logic                    leader;
    logic [NUM_TRIGGERS-1:0] grp_vec;
    op_vec_c = '0;
    op_hit_c = 1'b0;
    leader   = 1'b0;
    grp_vec  = '0;
    for (int g = 0; g < BYTES_PER_OP; g++) begin
      leader = 1'b1;
      for (int b = 0; b < g; b++) begin
        if (byte_key_c[b] == byte_key_c[g]) leader = 1'b0;
      end
      grp_vec = '0;
      for (int b = 0; b < BYTES_PER_OP; b++) begin
        if (byte_key_c[b] == byte_key_c[g]) grp_vec = grp_vec | byte_hit_c[b];
      end
      if (!op_hit_c && leader && (|grp_vec)) begin
        op_vec_c = grp_vec;
        op_hit_c = 1'b1;
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hit_vec_q   <= '0;
      hit_idx_q   <= '0;
      rv_q        <= 1'b0;
      vec_out_q   <= '0;
      idx_out_q   <= '0;
      found_out_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_vec_q   <= hit_vec_d;
      hit_idx_q   <= hit_idx_d;
      rv_q        <= rv_d;
      vec_out_q   <= vec_out_d;
      idx_out_q   <= idx_out_d;
      found_out_q <= found_out_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state: accept, scan one op per cycle, publish result for one cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_vec_d   = hit_vec_q;
    hit_idx_d   = hit_idx_q;
    rv_d        = 1'b0;
    vec_out_d   = vec_out_q;
    idx_out_d   = idx_out_q;
    found_out_d = found_out_q;
    overrun_d   = overrun_q;
    capture_c   = 1'b0;

    if (bus.instr_valid_i && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid_i) begin
          capture_c = 1'b1;
          cnt_d     = '0;
          hit_vec_d = '0;
          hit_idx_d = '0;
          state_d   = short_c ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (op_hit_c) begin
          hit_vec_d = op_vec_c;
          hit_idx_d = cnt_q;
          state_d   = ST_DONE;
        end else if (cnt_q == last_idx_c) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        rv_d        = 1'b1;
        vec_out_d   = hit_vec_q;
        idx_out_d   = hit_idx_q;
        found_out_d = |hit_vec_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy_o              = (state_q != ST_IDLE);
  assign bus.result_valid_o      = rv_q;
  assign bus.trigger_match_mem_o = vec_out_q;
  assign bus.match_op_idx_o      = idx_out_q;
  assign bus.match_found_o       = found_out_q;
  assign bus.overrun_o           = overrun_q;
endmodule
